// File: rtl/kyber_msg_compress.sv
// Kyber decrypt message stage: applies Compress_q(x,1) to each incoming coefficient
// and packs the 256 message bits LSB-first into sixteen 16-bit words.
module kyber_msg_compress (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] coef_in,
    input  logic        coef_valid,
    output logic [15:0] word_out,
    output logic        word_valid,
    output logic [3:0]  word_idx,
    output logic        busy,
    output logic        done,
    output logic        err_range
);

    localparam int unsigned Q       = 3329;
    localparam int unsigned N_COEF  = 256;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned N_WORDS = N_COEF / WORD_W;
    localparam int unsigned CNT_W   = $clog2(N_COEF);
    localparam int unsigned BIT_W   = $clog2(WORD_W);
    localparam int unsigned IDX_W   = $clog2(N_WORDS);

    // Compress_q(x,1) is 1 exactly on the closed interval [ceil(Q/4), floor(3Q/4)].
    localparam logic [15:0] Q_C   = 16'(Q);
    localparam logic [15:0] Q2_C  = 16'(2 * Q);
    localparam logic [15:0] LO_C  = 16'((Q + 3) / 4);
    localparam logic [15:0] HI_C  = 16'((3 * Q) / 4);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               busy_q;
    logic               err_q;

    logic               bit_q;
    logic               bit_vld_q;
    logic [CNT_W-1:0]   bit_idx_q;
    logic [WORD_W-2:0]  pack_q;
    logic [WORD_W-1:0]  pack_d;

    logic [WORD_W-1:0]  word_q;
    logic               word_valid_q;
    logic [IDX_W-1:0]   word_idx_q;
    logic               done_q;

    logic               accept_c;
    logic               range_err_c;
    logic [15:0]        red_c;
    logic               bit_c;
    logic               word_last_c;

    // Single conditional subtract; inputs >= 2Q are flagged but still processed.
    always_comb begin
        accept_c    = (state_q == COLLECT) && coef_valid;
        range_err_c = (coef_in >= Q2_C);
        red_c       = (coef_in >= Q_C) ? 16'(coef_in - Q_C) : coef_in;
        bit_c       = (red_c >= LO_C) && (red_c <= HI_C);
        cnt_d       = CNT_W'(cnt_q + 1'b1);
        pack_d      = {bit_q, pack_q};
        word_last_c = &bit_idx_q[BIT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            bit_q        <= 1'b0;
            bit_vld_q    <= 1'b0;
            bit_idx_q    <= '0;
            pack_q       <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            word_idx_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            done_q       <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= COLLECT;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                COLLECT: begin
                    if (accept_c) begin
                        cnt_q <= cnt_d;
                        if (cnt_q == CNT_W'(N_COEF - 1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Leave once the final word has been presented with done.
                    if (done_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (accept_c && range_err_c) begin
                err_q <= 1'b1;
            end

            // Stage 1: registered message bit and its coefficient index.
            bit_vld_q <= accept_c;
            if (accept_c) begin
                bit_q     <= bit_c;
                bit_idx_q <= cnt_q;
            end

            // Stage 2: shift into the packer; publish on the 16th bit of a word.
            if (bit_vld_q) begin
                pack_q <= pack_d[WORD_W-1:1];
                if (word_last_c) begin
                    word_q       <= pack_d;
                    word_valid_q <= 1'b1;
                    word_idx_q   <= bit_idx_q[CNT_W-1:BIT_W];
                    done_q       <= &bit_idx_q;
                end
            end
        end
    end

    assign word_out   = word_q;
    assign word_valid = word_valid_q;
    assign word_idx   = word_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_range  = err_q;

endmodule

// File: tb/tb_kyber_msg_compress.sv
// Scoreboarded bench for kyber_msg_compress: directed and randomized messages are
// checked against an arithmetic Compress_q(x,1) reference model.
module tb_kyber_msg_compress;

    localparam int unsigned Q = 3329;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] coef_in;
    logic        coef_valid;
    logic [15:0] word_out;
    logic        word_valid;
    logic [3:0]  word_idx;
    logic        busy;
    logic        done;
    logic        err_range;

    kyber_msg_compress dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .coef_in    (coef_in),
        .coef_valid (coef_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_idx   (word_idx),
        .busy       (busy),
        .done       (done),
        .err_range  (err_range)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        logic [3:0]  idx;
        logic        d;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned msg[256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // round(2x/Q) mod 2 for a once-reduced value; anything still >= Q compresses to 0.
    function automatic logic model_bit(input int unsigned c);
        int unsigned x;
        x = (c >= Q) ? c - Q : c;
        if (x >= Q) return 1'b0;
        return (((4 * x + Q) / (2 * Q)) % 2) == 1;
    endfunction

    function automatic logic model_err();
        for (int k = 0; k < 256; k++) if (msg[k] >= 2 * Q) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_words(input int nwords);
        exp_t e;
        for (int w = 0; w < nwords; w++) begin
            e.w = '0;
            for (int b = 0; b < 16; b++) e.w[b] = model_bit(msg[16 * w + b]);
            e.idx = 4'(w);
            e.d   = (w == 15);
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every word_valid pops the scoreboard; done must only ride with a word.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (word_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", {16'h0, word_out}, 32'hdead);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("word_out", {16'h0, word_out}, {16'h0, e.w});
                    chk("word_idx", {28'h0, word_idx}, {28'h0, e.idx});
                    chk("done", {31'h0, done}, {31'h0, e.d});
                end
            end else if (done === 1'b1) begin
                chk("done_without_word", 32'd1, 32'd0);
            end
        end
    end

    task automatic send(input int gap_pct, input bit noise, input int ncoef);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", {31'h0, busy}, 32'd1);
        for (int k = 0; k < ncoef; k++) begin
            while ($urandom_range(99) < gap_pct) begin
                coef_valid = 1'b0;
                coef_in    = 16'($urandom);
                start      = noise ? 1'($urandom_range(1)) : 1'b0;
                tick();
            end
            coef_valid = 1'b1;
            coef_in    = 16'(msg[k]);
            start      = noise ? 1'($urandom_range(1)) : 1'b0;
            tick();
        end
        start      = 1'b0;
        coef_valid = noise;
        coef_in    = 16'h1234;
        tick();
        tick();
        coef_valid = 1'b0;
    endtask

    task automatic finish_msg(input string name);
        logic exp_err;
        exp_err = model_err();
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        chk({name, "_drain"}, sb.size(), 0);
        sb.delete();
        chk({name, "_err_range"}, {31'h0, err_range}, {31'h0, exp_err});
        tick();
        tick();
        chk({name, "_busy_idle"}, {31'h0, busy}, 32'd0);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_word_out"}, {16'h0, word_out}, 32'd0);
        chk({name, "_word_valid"}, {31'h0, word_valid}, 32'd0);
        chk({name, "_word_idx"}, {28'h0, word_idx}, 32'd0);
        chk({name, "_busy"}, {31'h0, busy}, 32'd0);
        chk({name, "_done"}, {31'h0, done}, 32'd0);
        chk({name, "_err_range"}, {31'h0, err_range}, 32'd0);
    endtask

    initial begin
        int unsigned s3[12];
        s3 = '{832, 833, 2496, 2497, 0, 3328, 1664, 1665, 4994, 3329, 6657, 6658};

        reset      = 1'b1;
        start      = 1'b0;
        coef_valid = 1'b0;
        coef_in    = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_idle_outputs("reset");

        // All-zero message.
        for (int k = 0; k < 256; k++) msg[k] = 0;
        push_words(16);
        send(0, 1'b0, 256);
        finish_msg("zeros");

        // Mid-scale message, every bit set.
        for (int k = 0; k < 256; k++) msg[k] = 1665;
        push_words(16);
        send(0, 1'b0, 256);
        finish_msg("ones");

        // Interval edges and reduction cases in word 0 (bits 1,2,6,7,8 set by the rule).
        for (int k = 0; k < 256; k++) msg[k] = (k < 12) ? s3[k] : 0;
        push_words(16);
        send(0, 1'b0, 256);
        finish_msg("edges");

        // Random gaps with alternating bits.
        for (int k = 0; k < 256; k++) msg[k] = (k % 2 == 0) ? 1665 : 0;
        push_words(16);
        send(50, 1'b0, 256);
        finish_msg("gaps");

        // Reset after 100 coefficients: only the six complete words may appear.
        for (int k = 0; k < 256; k++) msg[k] = 1665;
        push_words(6);
        send(0, 1'b0, 100);
        chk("pre_reset_words", sb.size(), 0);
        reset = 1'b1;
        #2;
        check_idle_outputs("in_reset");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check_idle_outputs("after_reset");
        push_words(16);
        send(0, 1'b0, 256);
        finish_msg("post_reset");

        // Noise: coef_valid in IDLE, start pulses during COLLECT, coef_valid in DRAIN.
        coef_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            coef_in = 16'($urandom_range(3000));
            tick();
        end
        coef_valid = 1'b0;
        chk("idle_coef_busy", {31'h0, busy}, 32'd0);
        push_words(16);
        send(30, 1'b1, 256);
        finish_msg("noise");

        // Randomized messages, occasionally out of range.
        for (int m = 0; m < 6; m++) begin
            for (int k = 0; k < 256; k++)
                msg[k] = ($urandom_range(19) == 0) ? $urandom_range(65535) : $urandom_range(2 * Q - 1);
            push_words(16);
            send(int'($urandom_range(60)), 1'($urandom_range(1)), 256);
            finish_msg("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
